// File: rtl/fifo_rd_ctrl_if.sv
// fifo_rd_ctrl_if: read-side FIFO bus. It carries the synchronised pointer
// exchange, the memory read port and the valid/ready output stage.
// master = read controller, slave = memory/consumer/write-side peer.
interface fifo_rd_ctrl_if #(
    parameter int WIDTH        = 8,
    parameter int address_bits = 4
);
    logic [address_bits:0]   wptr_gray;
    logic [WIDTH-1:0]        mem_rdata;
    logic [address_bits-1:0] raddr;
    logic [address_bits:0]   rptr_gray;
    logic [WIDTH-1:0]        rd_data;
    logic                    rd_valid;
    logic                    rd_ready;
    logic                    empty;
    logic                    almost_empty;

    modport master (
        input  wptr_gray, mem_rdata, rd_ready,
        output raddr, rptr_gray, rd_data, rd_valid, empty, almost_empty
    );

    modport slave (
        output wptr_gray, mem_rdata, rd_ready,
        input  raddr, rptr_gray, rd_data, rd_valid, empty, almost_empty
    );
endinterface

// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl: read-side controller of the dual-clock FIFO.
// Owns the read pointer, synchronises the Gray write pointer into rclk,
// flags empty and presents words through a registered valid/ready stage.
// Optional feature: define FIFO_RD_ALMOST_EMPTY_EN to build the
// occupancy-based almost_empty flag; otherwise almost_empty is 0 out of reset.
module fifo_rd_ctrl #(
    parameter int WIDTH               = 8,
    parameter int no_of_addresses     = 16,
    parameter int address_bits        = $clog2(no_of_addresses),
    parameter int ALMOST_EMPTY_THRESH = 2
) (
    input  logic           rclk,
    input  logic           rst,
    fifo_rd_ctrl_if.master bus
);
    localparam int unsigned PW = $unsigned(address_bits + 1);

    logic [PW-1:0]    wq1;
    logic [PW-1:0]    wq2;
    logic [PW-1:0]    rbin;
    logic [PW-1:0]    rgray;
    logic [PW-1:0]    rbin_next;
    logic [PW-1:0]    rgray_next;
    logic [WIDTH-1:0] rd_data_q;
    logic             rd_valid_q;
    logic             empty_q;
    logic             almost_empty_q;
    logic             fetch;
    logic             pop;

    // Reject depths that are not a power of two and out-of-range thresholds
    if ((no_of_addresses < 4) || (no_of_addresses != (1 << address_bits)) ||
        (ALMOST_EMPTY_THRESH < 0) || (ALMOST_EMPTY_THRESH > no_of_addresses)) begin : g_bad_params
        $error("fifo_rd_ctrl: bad depth or almost-empty threshold");
    end

    assign bus.raddr        = rbin[address_bits-1:0];
    assign bus.rptr_gray    = rgray;
    assign bus.rd_data      = rd_data_q;
    assign bus.rd_valid     = rd_valid_q;
    assign bus.empty        = empty_q;
    assign bus.almost_empty = almost_empty_q;

    // Fetch when a word is available and the output stage is free or draining
    always_comb begin
        fetch      = !empty_q && (!rd_valid_q || bus.rd_ready);
        pop        = rd_valid_q && bus.rd_ready;
        rbin_next  = rbin + PW'(fetch);
        rgray_next = rbin_next ^ (rbin_next >> 1);
    end

    // Two-flop synchroniser of the write pointer into the read domain
    always_ff @(posedge rclk or posedge rst) begin
        if (rst) begin
            wq1 <= '0;
            wq2 <= '0;
        end else begin
            wq1 <= bus.wptr_gray;
            wq2 <= wq1;
        end
    end

    // Read pointer; advancing only on fetch gives the hold rule for free
    always_ff @(posedge rclk or posedge rst) begin
        if (rst) begin
            rbin  <= '0;
            rgray <= '0;
        end else begin
            rbin  <= rbin_next;
            rgray <= rgray_next;
        end
    end

    // Output stage: load on fetch, drop valid on a pop with nothing behind it
    always_ff @(posedge rclk or posedge rst) begin
        if (rst) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else if (fetch) begin
            rd_data_q  <= bus.mem_rdata;
            rd_valid_q <= 1'b1;
        end else if (pop) begin
            rd_valid_q <= 1'b0;
        end
    end

    // Empty looks ahead at the pointer after this cycle's fetch
    always_ff @(posedge rclk or posedge rst) begin
        if (rst) begin
            empty_q <= 1'b1;
        end else begin
            empty_q <= (rgray_next == wq2);
        end
    end

`ifdef FIFO_RD_ALMOST_EMPTY_EN
    logic [PW-1:0] wbin;
    logic [PW-1:0] occ_next;

    // Gray-to-binary: binary bit i is the XOR of all Gray bits at or above i
    always_comb begin
        wbin = '0;
        for (int unsigned i = 0; i < PW; i++) begin
            wbin[i] = ^(wq2 >> i);
        end
        occ_next = wbin - rbin_next;
    end

    // Low-occupancy flag from the modulo distance between the pointers
    always_ff @(posedge rclk or posedge rst) begin
        if (rst) begin
            almost_empty_q <= 1'b1;
        end else begin
            almost_empty_q <= (occ_next <= PW'(ALMOST_EMPTY_THRESH));
        end
    end
`else
    // Feature not built: flag is only a reset indicator
    always_ff @(posedge rclk or posedge rst) begin
        if (rst) begin
            almost_empty_q <= 1'b1;
        end else begin
            almost_empty_q <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// tb_fifo_rd_ctrl: directed bench for fifo_rd_ctrl with a count-based
// reference model and per-cycle output comparison.
module tb_fifo_rd_ctrl;
    localparam int W         = 8;
    localparam int N         = 16;
    localparam int AW        = 4;
    localparam int PW        = AW + 1;
    localparam int AE_THRESH = 2;

    logic rclk = 1'b0;
    logic rst  = 1'b1;
    always #5 rclk = ~rclk;

    fifo_rd_ctrl_if #(.WIDTH(W), .address_bits(AW)) bus ();

    fifo_rd_ctrl #(
        .WIDTH(W), .no_of_addresses(N), .address_bits(AW), .ALMOST_EMPTY_THRESH(AE_THRESH)
    ) dut (
        .rclk(rclk),
        .rst (rst),
        .bus (bus)
    );

    // Bench-side FIFO memory, read asynchronously at raddr
    logic [W-1:0] mem [N];
    assign bus.mem_rdata = mem[bus.raddr];

    int n_checks = 0;
    int n_pass   = 0;
    bit running  = 1'b0;

    // Write side: total words written since reset, and their values in order
    int           wcount = 0;
    logic [W-1:0] words [$];
    logic [W-1:0] poplog [$];

    // Reference model: counts of words written / visible / fetched
    int           m_rd    = 0;
    bit           m_valid = 1'b0;
    logic [W-1:0] m_data  = '0;
    bit           m_empty = 1'b1;
    bit           m_ae    = 1'b1;
    int           w_d1    = 0;
    int           w_d2    = 0;
    int           vis_old;
    bit           m_fetch;

    function automatic logic [PW-1:0] gray(input int v);
        logic [PW-1:0] b;
        b = PW'(v);
        return b ^ (b >> 1);
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    // One cycle from one stimulus point (negedge+1) to the next
    task automatic cyc();
        @(negedge rclk);
        #1;
    endtask

    task automatic write_word(input logic [W-1:0] d);
        mem[wcount % N] = d;
        words.push_back(d);
        wcount++;
        bus.wptr_gray = gray(wcount);
    endtask

    task automatic do_reset();
        #1;
        rst           = 1'b1;
        wcount        = 0;
        bus.wptr_gray = '0;
        bus.rd_ready  = 1'b0;
        words.delete();
        poplog.delete();
        #1;
        check("rst_empty",     32'(bus.empty),        32'd1);
        check("rst_rd_valid",  32'(bus.rd_valid),     32'd0);
        check("rst_raddr",     32'(bus.raddr),        32'd0);
        check("rst_rptr_gray", 32'(bus.rptr_gray),    32'd0);
        check("rst_rd_data",   32'(bus.rd_data),      32'd0);
        check("rst_almost",    32'(bus.almost_empty), 32'd1);
        cyc();
        cyc();
        rst = 1'b0;
        cyc();
    endtask

    task automatic wait_valid(input int max_cycles);
        int k;
        k = 0;
        while (!bus.rd_valid && k < max_cycles) begin
            cyc();
            k++;
        end
        check("wait_rd_valid", 32'(bus.rd_valid), 32'd1);
    endtask

    // Model update at each active edge from the pre-edge ready and write count
    initial begin
        forever begin
            @(posedge rclk or posedge rst);
            if (rst) begin
                m_rd = 0; m_valid = 1'b0; m_data = '0; m_empty = 1'b1; m_ae = 1'b1;
                w_d1 = 0; w_d2 = 0;
            end else begin
                vis_old = w_d2;
                w_d2    = w_d1;
                w_d1    = wcount;
                m_fetch = !m_empty && (!m_valid || bus.rd_ready);
                if (m_fetch) begin
                    m_data  = words[m_rd];
                    m_rd++;
                    m_valid = 1'b1;
                end else if (m_valid && bus.rd_ready) begin
                    m_valid = 1'b0;
                end
                m_empty = (m_rd == vis_old);
`ifdef FIFO_RD_ALMOST_EMPTY_EN
                m_ae = ((vis_old - m_rd) <= AE_THRESH);
`else
                m_ae = 1'b0;
`endif
            end
        end
    end

    // Per-cycle comparison of every output against the model
    initial begin
        forever begin
            @(negedge rclk);
            if (running) begin
                check("cmp_empty",     32'(bus.empty),        32'(m_empty));
                check("cmp_rd_valid",  32'(bus.rd_valid),     32'(m_valid));
                check("cmp_rd_data",   32'(bus.rd_data),      32'(m_data));
                check("cmp_raddr",     32'(bus.raddr),        32'(m_rd % N));
                check("cmp_rptr_gray", 32'(bus.rptr_gray),    32'(gray(m_rd)));
                check("cmp_almost",    32'(bus.almost_empty), 32'(m_ae));
                if (bus.rd_valid && bus.rd_ready) poplog.push_back(bus.rd_data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, n_checks %0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] exp_ae_low;
        bus.wptr_gray = '0;
        bus.rd_ready  = 1'b0;
        for (int i = 0; i < N; i++) mem[i] = '0;
        cyc();
        running = 1'b1;

        // Single write: E1..E4 latency, last word sets empty on the fetch edge
        do_reset();
        bus.rd_ready = 1'b1;
        mem[0] = 8'hA5;
        words.push_back(8'hA5);
        wcount = 1;
        bus.wptr_gray = gray(1);
        cyc(); check("lat_e1_empty", 32'(bus.empty), 32'd1);
        cyc(); check("lat_e2_empty", 32'(bus.empty), 32'd1);
        cyc(); check("lat_e3_empty", 32'(bus.empty), 32'd0);
               check("lat_e3_valid", 32'(bus.rd_valid), 32'd0);
        cyc(); check("lat_e4_valid", 32'(bus.rd_valid), 32'd1);
               check("lat_e4_data",  32'(bus.rd_data), 32'hA5);
               check("lat_e4_empty", 32'(bus.empty), 32'd1);
               check("lat_e4_rptr",  32'(bus.rptr_gray), 32'd1);
        cyc(); check("single_drain_valid", 32'(bus.rd_valid), 32'd0);
               check("single_drain_empty", 32'(bus.empty), 32'd1);
               check("single_drain_rptr",  32'(bus.rptr_gray), 32'd1);

        // Backpressure: first word held, then three back-to-back pops
        do_reset();
        for (int i = 0; i < 4; i++) begin
            write_word(8'(8'h10 + i));
            cyc();
        end
        for (int i = 0; i < 6; i++) cyc();
        for (int i = 0; i < 5; i++) begin
            check("bp_hold_data",  32'(bus.rd_data), 32'h10);
            check("bp_hold_raddr", 32'(bus.raddr), 32'd1);
            check("bp_hold_valid", 32'(bus.rd_valid), 32'd1);
            cyc();
        end
        bus.rd_ready = 1'b1;
        cyc(); check("bp_stream_0", 32'(bus.rd_data), 32'h11);
        cyc(); check("bp_stream_1", 32'(bus.rd_data), 32'h12);
        cyc(); check("bp_stream_2", 32'(bus.rd_data), 32'h13);
               check("bp_last_empty", 32'(bus.empty), 32'd1);
        cyc(); check("bp_end_valid", 32'(bus.rd_valid), 32'd0);

        // Wrap-around: 20 words through a 16-deep FIFO
        do_reset();
        bus.rd_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            write_word(8'(8'h40 + i));
            cyc();
        end
        for (int i = 0; i < 8; i++) cyc();
        check("wrap_count", 32'(poplog.size()), 32'd20);
        for (int i = 0; i < 20 && i < poplog.size(); i++)
            check("wrap_data", 32'(poplog[i]), 32'(8'h40 + i));
        check("wrap_rptr_gray", 32'(bus.rptr_gray), 32'b11110);
        check("wrap_raddr",     32'(bus.raddr), 32'd4);
        check("wrap_empty",     32'(bus.empty), 32'd1);

        // Almost-empty: five words unpopped, then pop down to occupancy two
`ifdef FIFO_RD_ALMOST_EMPTY_EN
        exp_ae_low = 8'd1;
`else
        exp_ae_low = 8'd0;
`endif
        do_reset();
        check("ae_idle", 32'(bus.almost_empty), 32'(exp_ae_low));
        for (int i = 0; i < 5; i++) begin
            write_word(8'(8'h60 + i));
            cyc();
        end
        for (int i = 0; i < 4; i++) cyc();
        check("ae_five_words", 32'(bus.almost_empty), 32'd0);
        for (int i = 0; i < 2; i++) begin
            bus.rd_ready = 1'b1;
            cyc();
            bus.rd_ready = 1'b0;
            cyc();
        end
        check("ae_occ_two", 32'(bus.almost_empty), 32'(exp_ae_low));
        check("ae_occ_two_data", 32'(bus.rd_data), 32'h62);
        bus.rd_ready = 1'b1;
        for (int i = 0; i < 6; i++) cyc();

        // Reset in the middle of a transfer with three words still queued
        do_reset();
        for (int i = 0; i < 4; i++) begin
            write_word(8'(8'h70 + i));
            cyc();
        end
        wait_valid(10);
        #1;
        rst           = 1'b1;
        wcount        = 0;
        bus.wptr_gray = '0;
        words.delete();
        #1;
        check("mid_rst_valid", 32'(bus.rd_valid), 32'd0);
        check("mid_rst_empty", 32'(bus.empty), 32'd1);
        check("mid_rst_raddr", 32'(bus.raddr), 32'd0);
        check("mid_rst_rptr",  32'(bus.rptr_gray), 32'd0);
        check("mid_rst_data",  32'(bus.rd_data), 32'd0);
        check("mid_rst_ae",    32'(bus.almost_empty), 32'd1);
        bus.rd_ready = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) cyc();
        check("post_rst_no_valid", 32'(bus.rd_valid), 32'd0);
        check("post_rst_empty",    32'(bus.empty), 32'd1);
        bus.rd_ready = 1'b0;
        write_word(8'h99);
        cyc();
        wait_valid(10);
        check("post_rst_data", 32'(bus.rd_data), 32'h99);
        cyc();

        running = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
